// File: rtl/sparse_split_node.sv
// sparse_split_node: 2-entry FIFO that splits accumulator values into LSP/MSP pairs and checks vector length.
module sparse_split_node #(
  parameter int ACCUM_WIDTH = 48,
  parameter int SPLIT_WIDTH = 24,
  parameter int VECTOR_LEN = 16,
  localparam int IW = VECTOR_LEN > 1 ? $clog2(VECTOR_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACCUM_WIDTH-1:0] in_data,
  input  logic                   in_sparse_en,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACCUM_WIDTH-1:0] out_lsp,
  output logic [ACCUM_WIDTH-1:0] out_msp,
  output logic                   out_sparse_en,
  output logic                   out_last,
  output logic [IW-1:0]          out_idx,
  output logic                   len_err
);
  logic [ACCUM_WIDTH-1:0] mem_data [2];
  logic [IW-1:0]          mem_idx [2];
  logic [1:0]             mem_sp, mem_last, count;
  logic                   wp, rp, push, pop, at_end;
  logic [IW-1:0]          cnt;
  logic [ACCUM_WIDTH-1:0] hd, hi_mask;
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign at_end = cnt == IW'(VECTOR_LEN - 1);
  assign hi_mask = {ACCUM_WIDTH{1'b1}} << SPLIT_WIDTH;
  assign hd = out_valid ? mem_data[rp] : '0;
  assign out_sparse_en = out_valid && mem_sp[rp];
  assign out_last = out_valid && mem_last[rp];
  assign out_idx = out_valid ? mem_idx[rp] : '0;
  assign out_lsp = out_sparse_en ? hd & ~hi_mask : hd;
  assign out_msp = out_sparse_en ? hd & hi_mask : '0;
  // A length error is a last flag that disagrees with the counter reaching the end.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_data <= '{default: '0};
      mem_idx <= '{default: '0};
      mem_sp <= '0;
      mem_last <= '0;
      count <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wp] <= in_data;
        mem_sp[wp] <= in_sparse_en;
        mem_last[wp] <= in_last;
        mem_idx[wp] <= cnt;
        wp <= ~wp;
        cnt <= (in_last || at_end) ? '0 : cnt + IW'(1);
        if (in_last != at_end) len_err <= 1'b1;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: tb/tb_sparse_split_node.sv
// tb_sparse_split_node: scoreboard bench for sparse_split_node with VECTOR_LEN = 4.
module tb_sparse_split_node;
  localparam int AW = 48, SW = 24, VL = 4, IW = 2;
  typedef struct {
    logic [AW-1:0] lsp, msp;
    logic sp, last;
    logic [IW-1:0] idx;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_sparse_en = 0, in_last = 0, out_ready = 0;
  logic [AW-1:0] in_data = '0;
  logic in_ready, out_valid, out_sparse_en, out_last, len_err;
  logic [AW-1:0] out_lsp, out_msp;
  logic [IW-1:0] out_idx;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, mcnt = 0;
  logic merr = 0;
  sparse_split_node #(.ACCUM_WIDTH(AW), .SPLIT_WIDTH(SW), .VECTOR_LEN(VL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sparse_en(in_sparse_en), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_lsp(out_lsp), .out_msp(out_msp), .out_sparse_en(out_sparse_en), .out_last(out_last),
    .out_idx(out_idx), .len_err(len_err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [AW-1:0] d, input logic sp, input logic last, input int idx);
    logic [AW-1:0] lo = (48'd1 << SW) - 48'd1;
    model.lsp = sp ? d & lo : d;
    model.msp = sp ? d & ~lo : '0;
    model.sp = sp;
    model.last = last;
    model.idx = IW'(idx);
  endfunction
  always @(negedge clk)
    if (!rst) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
      chk("len_err", len_err, merr);
      if (q.size() != 0) begin
        chk("out_lsp", out_lsp, q[0].lsp);
        chk("out_msp", out_msp, q[0].msp);
        chk("out_sparse_en", out_sparse_en, q[0].sp);
        chk("out_last", out_last, q[0].last);
        chk("out_idx", out_idx, q[0].idx);
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("idle_lsp", out_lsp, 0);
        chk("idle_msp", out_msp, 0);
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_sparse_en, in_last, mcnt));
        if (in_last != (mcnt == VL - 1)) merr = 1;
        mcnt = (in_last || mcnt == VL - 1) ? 0 : mcnt + 1;
      end
    end
  task automatic send(input logic [AW-1:0] d, input logic sp, input logic last);
    bit ok;
    int t = 0;
    in_valid = 1; in_data = d; in_sparse_en = sp; in_last = last;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk);
      t++;
    end while (!ok && t < 50);
    if (!ok) chk("send_timeout", 0, 1);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    out_ready = 1;
    while (q.size() != 0 && t < 50) begin @(posedge clk); t++; end
    #1 chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_len_err", len_err, 0);
    chk("rst_lsp", out_lsp, 0);
    chk("rst_msp", out_msp, 0);
    chk("rst_flags", {out_sparse_en, out_last, out_idx}, 0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1;
    send(48'h123456_789ABC, 1, 0);
    send(48'hFFFF_FFFF_FFFF, 0, 0);
    send(48'h0000_00FF_FFFF, 1, 0);
    send(48'hABCD_EF01_2345, 1, 1);
    for (int i = 0; i < 4; i++) send(48'(i * 48'h1111_0000_0101), i[0], i == 3);
    drain();
    chk("len_err_ok", len_err, 0);
    out_ready = 0;
    send(48'hAAAA_AAAA_AAAA, 1, 0);
    send(48'hBBBB_BBBB_BBBB, 0, 0);
    in_valid = 1; in_data = 48'hCCCC_CCCC_CCCC; in_sparse_en = 1; in_last = 0;
    repeat (3) @(posedge clk);
    #1 chk("full_in_ready", in_ready, 0);
    out_ready = 1;
    send(48'hCCCC_CCCC_CCCC, 1, 0);
    send(48'hDDDD_DDDD_DDDD, 1, 1);
    drain();
    for (int i = 0; i < 12; i++) send(48'($urandom) << 16 | 48'(i), 1'($urandom), i % 4 == 3);
    drain();
    send(48'h0000_0000_0001, 1, 0);
    send(48'h0000_0000_0002, 1, 1);
    drain();
    chk("len_err_set", len_err, 1);
    send(48'h0000_0000_0003, 0, 0);
    drain();
    chk("len_err_sticky", len_err, 1);
    out_ready = 0;
    send(48'h1234_0000_0001, 1, 0);
    send(48'h1234_0000_0002, 1, 0);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_lsp", out_lsp, 0);
    chk("arst_len_err", len_err, 0);
    q.delete(); mcnt = 0; merr = 0;
    @(posedge clk); #1 rst = 0;
    out_ready = 1;
    send(48'h5555_6666_7777, 1, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
